// File: rtl/bp_pkg.sv
// Shared types, opcodes and decode helpers for the fetch-stage branch predictor.
// Immediate helpers return values already sign-extended to the address width.
package bp_pkg;

  localparam int ADDR_WIDTH = 32;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [2:0] F3_JALR   = 3'b000;

  typedef logic [1:0] pht_cnt_t;

  localparam pht_cnt_t PHT_RESET = 2'b01;
  localparam pht_cnt_t PHT_MAX   = 2'b11;
  localparam pht_cnt_t PHT_MIN   = 2'b00;

  // x1 (ra) and x5 (t0) are the link registers that drive RAS hints.
  function automatic logic is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] imm_j(input logic [31:0] instr);
    return {{(ADDR_WIDTH-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] imm_b(input logic [31:0] instr);
    return {{(ADDR_WIDTH-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch, RAS, commit and CSR counter signals of the branch predictor.
// master = surrounding pipeline, slave = predictor.
interface branch_predictor_if #(
    parameter int PHT_WIDTH = 10
);
    import bp_pkg::*;

    // Handshake: there is no ready. fetch_bp_valid and commit_bp_valid each qualify their
    // payload for exactly the cycle they are high and are always accepted that cycle.
    logic                  fetch_bp_valid;
    logic [ADDR_WIDTH-1:0] fetch_bp_pc;
    logic [31:0]           fetch_bp_instr;

    logic                  bp_fetch_jump;
    logic [ADDR_WIDTH-1:0] bp_fetch_next_pc;
    logic [PHT_WIDTH-1:0]  bp_fetch_pht_idx;
    logic                  bp_fetch_pred_taken;

    logic [ADDR_WIDTH-1:0] bp_ras_addr;
    logic                  bp_ras_push;
    logic                  bp_ras_pop;
    logic [ADDR_WIDTH-1:0] ras_bp_addr;

    logic                  commit_bp_valid;
    logic [PHT_WIDTH-1:0]  commit_bp_pht_idx;
    logic                  commit_bp_taken;
    logic                  commit_bp_pred_taken;

    logic                  bp_csrf_branch_num_add;
    logic                  bp_csrf_branch_predicted_add;

    modport master (
        output fetch_bp_valid, fetch_bp_pc, fetch_bp_instr, ras_bp_addr,
               commit_bp_valid, commit_bp_pht_idx, commit_bp_taken, commit_bp_pred_taken,
        input  bp_fetch_jump, bp_fetch_next_pc, bp_fetch_pht_idx, bp_fetch_pred_taken,
               bp_ras_addr, bp_ras_push, bp_ras_pop,
               bp_csrf_branch_num_add, bp_csrf_branch_predicted_add
    );

    modport slave (
        input  fetch_bp_valid, fetch_bp_pc, fetch_bp_instr, ras_bp_addr,
               commit_bp_valid, commit_bp_pht_idx, commit_bp_taken, commit_bp_pred_taken,
        output bp_fetch_jump, bp_fetch_next_pc, bp_fetch_pht_idx, bp_fetch_pred_taken,
               bp_ras_addr, bp_ras_push, bp_ras_pop,
               bp_csrf_branch_num_add, bp_csrf_branch_predicted_add
    );

endinterface

// File: rtl/bp_pht.sv
// Pattern history table: 2-bit saturating counters, asynchronous read, synchronous update.
// A same-cycle read of the entry being written returns the old value.
module bp_pht
    import bp_pkg::*;
#(
    parameter int PHT_WIDTH = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PHT_WIDTH-1:0] rd_idx,
    output pht_cnt_t             rd_cnt,
    input  logic                 wr_en,
    input  logic [PHT_WIDTH-1:0] wr_idx,
    input  logic                 wr_taken
);

    localparam int DEPTH = 1 << PHT_WIDTH;

    pht_cnt_t cnt [DEPTH];

    assign rd_cnt = cnt[rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt[i] <= PHT_RESET;
            end
        end else if (wr_en) begin
            if (wr_taken && (cnt[wr_idx] != PHT_MAX)) begin
                cnt[wr_idx] <= cnt[wr_idx] + 2'd1;
            end else if (!wr_taken && (cnt[wr_idx] != PHT_MIN)) begin
                cnt[wr_idx] <= cnt[wr_idx] - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage predictor: classifies JAL/JALR/BRANCH, drives RAS push/pop, predicts next PC
// with a gshare PHT trained at commit, and pulses the branch statistics counters.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int PHT_WIDTH = 10,
    parameter int GHR_WIDTH = 10
) (
    input logic               clk,
    input logic               rst,
    branch_predictor_if.slave bp
);

    logic [GHR_WIDTH-1:0]  ghr;
    logic [PHT_WIDTH-1:0]  fetch_idx;
    pht_cnt_t              rd_cnt;
    logic                  cnt_taken;
    logic [6:0]            opcode;
    logic [4:0]            rd;
    logic [4:0]            rs1;
    logic [2:0]            funct3;
    logic [ADDR_WIDTH-1:0] pc_plus4;
    logic                  rd_link;
    logic                  rs1_link;
    logic                  jalr_pop;
    logic                  num_add_q;
    logic                  predicted_add_q;

    assign opcode    = bp.fetch_bp_instr[6:0];
    assign rd        = bp.fetch_bp_instr[11:7];
    assign funct3    = bp.fetch_bp_instr[14:12];
    assign rs1       = bp.fetch_bp_instr[19:15];
    assign pc_plus4  = bp.fetch_bp_pc + ADDR_WIDTH'(4);
    assign rd_link   = is_link(rd);
    assign rs1_link  = is_link(rs1);
    // Coroutine swap (both link, different regs) pops; a plain call through the same link reg does not.
    assign jalr_pop  = rs1_link && !(rd_link && (rd == rs1));
    assign fetch_idx = bp.fetch_bp_pc[PHT_WIDTH+1:2] ^ PHT_WIDTH'(ghr);
    assign cnt_taken = (rd_cnt >= 2'd2);

    bp_pht #(
        .PHT_WIDTH(PHT_WIDTH)
    ) u_pht (
        .clk     (clk),
        .rst     (rst),
        .rd_idx  (fetch_idx),
        .rd_cnt  (rd_cnt),
        .wr_en   (bp.commit_bp_valid),
        .wr_idx  (bp.commit_bp_pht_idx),
        .wr_taken(bp.commit_bp_taken)
    );

    always_comb begin
        bp.bp_fetch_jump       = 1'b0;
        bp.bp_fetch_next_pc    = '0;
        bp.bp_fetch_pht_idx    = '0;
        bp.bp_fetch_pred_taken = 1'b0;
        bp.bp_ras_addr         = '0;
        bp.bp_ras_push         = 1'b0;
        bp.bp_ras_pop          = 1'b0;
        if (bp.fetch_bp_valid) begin
            bp.bp_fetch_next_pc = pc_plus4;
            bp.bp_ras_addr      = pc_plus4;
            bp.bp_fetch_pht_idx = fetch_idx;
            case (opcode)
                OP_JAL: begin
                    bp.bp_fetch_jump    = 1'b1;
                    bp.bp_fetch_next_pc = bp.fetch_bp_pc + imm_j(bp.fetch_bp_instr);
                    bp.bp_ras_push      = rd_link;
                end
                OP_JALR: begin
                    if (funct3 == F3_JALR) begin
                        bp.bp_ras_push = rd_link;
                        bp.bp_ras_pop  = jalr_pop;
                        if (jalr_pop) begin
                            bp.bp_fetch_jump    = 1'b1;
                            bp.bp_fetch_next_pc = bp.ras_bp_addr;
                        end
                    end
                end
                OP_BRANCH: begin
                    bp.bp_fetch_pred_taken = cnt_taken;
                    bp.bp_fetch_jump       = cnt_taken;
                    if (cnt_taken) begin
                        bp.bp_fetch_next_pc = bp.fetch_bp_pc + imm_b(bp.fetch_bp_instr);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ghr             <= '0;
            num_add_q       <= 1'b0;
            predicted_add_q <= 1'b0;
        end else begin
            num_add_q       <= bp.commit_bp_valid;
            predicted_add_q <= bp.commit_bp_valid &&
                               (bp.commit_bp_taken == bp.commit_bp_pred_taken);
            if (bp.commit_bp_valid) begin
                ghr <= {ghr[GHR_WIDTH-2:0], bp.commit_bp_taken};
            end
        end
    end

    assign bp.bp_csrf_branch_num_add       = num_add_q;
    assign bp.bp_csrf_branch_predicted_add = predicted_add_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized traffic
// compared against a field-level reference model of prediction, PHT training and history.
module tb_branch_predictor;
  localparam int PW = 10;
  localparam int GW = 10;
  localparam int PHT_N = 1 << PW;
  localparam int VW = 3 + 2 * 32 + PW + 1;
  localparam int K_JAL = 0, K_JALR = 1, K_BR = 2, K_OTHER = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // clock / reset
  always #5 clk = ~clk;

  branch_predictor_if #(.PHT_WIDTH(PW)) bif ();

  branch_predictor #(.PHT_WIDTH(PW), .GHR_WIDTH(GW)) dut (
    .clk(clk),
    .rst(rst),
    .bp (bif)
  );

  // reference model state
  int pht_m [PHT_N];
  int ghr_m;
  logic [1:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;

  logic        cur_v;
  int          cur_k, cur_rd, cur_rs1, cur_imm, cur_f3;
  logic [31:0] cur_pc, cur_ras;
  logic        cur_cv, cur_ct, cur_cp;
  int          cur_cidx;

  function automatic logic [31:0] encode(input int k, input int rd, input int rs1,
                                         input int imm, input int f3);
    logic [31:0] im;
    logic [31:0] r;
    logic [4:0]  d;
    logic [4:0]  s;
    logic [2:0]  f;
    logic [6:0]  op;
    im = imm;
    d = rd[4:0];
    s = rs1[4:0];
    f = f3[2:0];
    r = $urandom();
    case (k)
      K_JAL:  return {im[20], im[10:1], im[11], im[19:12], d, 7'h6F};
      K_JALR: return {im[11:0], s, f, d, 7'h67};
      K_BR:   return {im[12], im[10:5], d, s, f, im[4:1], im[11], 7'h63};
      default: begin
        case (r[2:0])
          3'd0: op = 7'h13;
          3'd1: op = 7'h33;
          3'd2: op = 7'h03;
          3'd3: op = 7'h23;
          3'd4: op = 7'h37;
          3'd5: op = 7'h17;
          3'd6: op = 7'h73;
          default: op = 7'h0F;
        endcase
        return {r[31:7], op};
      end
    endcase
  endfunction

  function automatic logic lnk(input int r);
    return (r == 1) || (r == 5);
  endfunction

  // Expected {jump, next_pc, pht_idx, pred_taken, ras_addr, push, pop} from the instruction fields.
  function automatic logic [VW-1:0] model_fetch();
    logic [31:0] nxt, ra;
    logic [PW-1:0] idx;
    int idx_i;
    logic jmp, prd, psh, pp;
    if (!cur_v) return '0;
    nxt = cur_pc + 32'd4;
    ra = cur_pc + 32'd4;
    idx_i = int'((cur_pc / 4) % PHT_N) ^ ghr_m;
    idx = idx_i[PW-1:0];
    jmp = 0; prd = 0; psh = 0; pp = 0;
    if (cur_k == K_JAL) begin
      jmp = 1;
      nxt = cur_pc + 32'(cur_imm);
      psh = lnk(cur_rd);
    end else if (cur_k == K_JALR && cur_f3 == 0) begin
      psh = lnk(cur_rd);
      if (lnk(cur_rs1) && !lnk(cur_rd)) pp = 1;
      else if (lnk(cur_rs1) && lnk(cur_rd) && cur_rd != cur_rs1) pp = 1;
      if (pp) begin
        jmp = 1;
        nxt = cur_ras;
      end
    end else if (cur_k == K_BR) begin
      prd = (pht_m[idx_i] >= 2);
      jmp = prd;
      if (prd) nxt = cur_pc + 32'(cur_imm);
    end
    return {jmp, nxt, idx, prd, ra, psh, pp};
  endfunction

  function automatic logic [VW-1:0] dut_fetch();
    return {bif.bp_fetch_jump, bif.bp_fetch_next_pc, bif.bp_fetch_pht_idx,
            bif.bp_fetch_pred_taken, bif.bp_ras_addr, bif.bp_ras_push, bif.bp_ras_pop};
  endfunction

  function automatic logic [31:0] pc_for_idx(input int t);
    return 32'h2000 + 32'(((t ^ ghr_m) % PHT_N) * 4);
  endfunction

  // driver tasks
  task automatic drive_fetch(input logic v, input int k, input int rd, input int rs1,
                             input int imm, input int f3, input logic [31:0] pc,
                             input logic [31:0] ras);
    cur_v = v; cur_k = k; cur_rd = rd; cur_rs1 = rs1; cur_imm = imm; cur_f3 = f3;
    cur_pc = pc; cur_ras = ras;
    bif.fetch_bp_valid = v;
    bif.fetch_bp_pc = pc;
    bif.fetch_bp_instr = encode(k, rd, rs1, imm, f3);
    bif.ras_bp_addr = ras;
  endtask

  task automatic drive_commit(input logic v, input int idx, input logic t, input logic p);
    cur_cv = v; cur_cidx = idx; cur_ct = t; cur_cp = p;
    bif.commit_bp_valid = v;
    bif.commit_bp_pht_idx = idx[PW-1:0];
    bif.commit_bp_taken = t;
    bif.commit_bp_pred_taken = p;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      ghr_m = 0;
      for (int i = 0; i < PHT_N; i++) pht_m[i] = 1;
      exp_q.push_back(2'b00);
    end else if (cur_cv) begin
      if (cur_ct && pht_m[cur_cidx] < 3) pht_m[cur_cidx]++;
      if (!cur_ct && pht_m[cur_cidx] > 0) pht_m[cur_cidx]--;
      ghr_m = ((ghr_m * 2) + int'(cur_ct)) % (1 << GW);
      exp_q.push_back({1'b1, cur_ct == cur_cp});
    end else begin
      exp_q.push_back(2'b00);
    end
    #1;
  endtask

  task automatic do_reset();
    drive_fetch(0, K_OTHER, 0, 0, 0, 0, 32'h0, 32'h0);
    drive_commit(0, 0, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    exp_q.push_back(2'b00);
  endtask

  task automatic test_reset();
    logic [1:0] want;
    drive_commit(1, 9, 1, 1);
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    drive_commit(0, 0, 0, 0);
    drive_fetch(1, K_BR, 2, 3, -8, 0, 32'h2000, 32'h0);
    exp_q.delete();
    #1;
    n_checks++; if (bif.bp_fetch_pred_taken !== 1'b0) $display("FAIL reset_pred got %b want 0", bif.bp_fetch_pred_taken); else n_pass++;
    n_checks++; if (bif.bp_fetch_next_pc !== 32'h2004) $display("FAIL reset_next got %h want 00002004", bif.bp_fetch_next_pc); else n_pass++;
    n_checks++; if (bif.bp_fetch_pht_idx !== '0) $display("FAIL reset_idx got %h want 0", bif.bp_fetch_pht_idx); else n_pass++;
    want = 2'b00;
    n_checks++; if ({bif.bp_csrf_branch_num_add, bif.bp_csrf_branch_predicted_add} !== want) $display("FAIL reset_csrf got %b want %b", {bif.bp_csrf_branch_num_add, bif.bp_csrf_branch_predicted_add}, want); else n_pass++;
    tick();
  endtask

  task automatic test_jal();
    do_reset();
    drive_fetch(1, K_JAL, 1, 0, 32'h100, 0, 32'h1000, 32'hDEAD0000);
    #1;
    n_checks++; if ({bif.bp_fetch_jump, bif.bp_ras_push, bif.bp_ras_pop} !== 3'b110) $display("FAIL jal_flags got %b want 110", {bif.bp_fetch_jump, bif.bp_ras_push, bif.bp_ras_pop}); else n_pass++;
    n_checks++; if (bif.bp_fetch_next_pc !== 32'h1100) $display("FAIL jal_next got %h want 00001100", bif.bp_fetch_next_pc); else n_pass++;
    n_checks++; if (bif.bp_ras_addr !== 32'h1004) $display("FAIL jal_ras_addr got %h want 00001004", bif.bp_ras_addr); else n_pass++;
    n_checks++; if (dut_fetch() !== model_fetch()) $display("FAIL jal_vec got %h want %h", dut_fetch(), model_fetch()); else n_pass++;
    tick();
  endtask

  task automatic test_jalr();
    int rd_t[5]  = '{0, 1, 1, 5, 2};
    int rs1_t[5] = '{1, 5, 1, 2, 3};
    logic push_t[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic pop_t[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [34:0] want;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive_fetch(1, K_JALR, rd_t[i], rs1_t[i], 0, 0, 32'h3000, 32'h1004);
      #1;
      want = {push_t[i], pop_t[i], pop_t[i], pop_t[i] ? 32'h1004 : 32'h3004};
      n_checks++; if ({bif.bp_ras_push, bif.bp_ras_pop, bif.bp_fetch_jump, bif.bp_fetch_next_pc} !== want) $display("FAIL jalr_case%0d got %h want %h", i, {bif.bp_ras_push, bif.bp_ras_pop, bif.bp_fetch_jump, bif.bp_fetch_next_pc}, want); else n_pass++;
      n_checks++; if (dut_fetch() !== model_fetch()) $display("FAIL jalr_vec%0d got %h want %h", i, dut_fetch(), model_fetch()); else n_pass++;
      tick();
    end
  endtask

  task automatic test_branch_train();
    do_reset();
    drive_commit(1, 3, 1, 0);
    tick();
    tick();
    drive_commit(0, 0, 0, 0);
    drive_fetch(1, K_BR, 2, 3, -8, 0, 32'h2000, 32'h0);
    #1;
    n_checks++; if (bif.bp_fetch_pht_idx !== 10'd3) $display("FAIL train_idx got %h want 003", bif.bp_fetch_pht_idx); else n_pass++;
    n_checks++; if ({bif.bp_fetch_pred_taken, bif.bp_fetch_jump} !== 2'b11) $display("FAIL train_pred got %b want 11", {bif.bp_fetch_pred_taken, bif.bp_fetch_jump}); else n_pass++;
    n_checks++; if (bif.bp_fetch_next_pc !== 32'h1FF8) $display("FAIL train_next got %h want 00001ff8", bif.bp_fetch_next_pc); else n_pass++;
    drive_fetch(0, K_OTHER, 0, 0, 0, 0, 32'h0, 32'h0);
    drive_commit(1, 3, 1, 1);
    repeat (3) tick();
    // saturated at 3: one not-taken keeps it taken, a second drops it to weak not-taken
    for (int i = 0; i < 2; i++) begin
      drive_commit(1, 3, 0, 1);
      tick();
      drive_commit(0, 0, 0, 0);
      drive_fetch(1, K_BR, 4, 4, 64, 1, pc_for_idx(3), 32'h0);
      #1;
      n_checks++; if (bif.bp_fetch_pred_taken !== (i == 0)) $display("FAIL sat_dec%0d got %b want %b", i, bif.bp_fetch_pred_taken, i == 0); else n_pass++;
      n_checks++; if (dut_fetch() !== model_fetch()) $display("FAIL sat_vec%0d got %h want %h", i, dut_fetch(), model_fetch()); else n_pass++;
      drive_fetch(0, K_OTHER, 0, 0, 0, 0, 32'h0, 32'h0);
    end
  endtask

  task automatic test_commit_pulse();
    logic [1:0] want;
    do_reset();
    drive_fetch(1, K_BR, 6, 7, 16, 0, pc_for_idx(5), 32'h0);
    drive_commit(1, 5, 1, 0);
    #1;
    n_checks++; if (bif.bp_fetch_pred_taken !== 1'b0) $display("FAIL same_cycle_old got %b want 0", bif.bp_fetch_pred_taken); else n_pass++;
    want = exp_q.pop_front();
    n_checks++; if ({bif.bp_csrf_branch_num_add, bif.bp_csrf_branch_predicted_add} !== want) $display("FAIL pulse_before got %b want %b", {bif.bp_csrf_branch_num_add, bif.bp_csrf_branch_predicted_add}, want); else n_pass++;
    tick();
    drive_commit(0, 0, 0, 0);
    drive_fetch(1, K_BR, 6, 7, 16, 0, 32'h2000, 32'h0);
    #1;
    want = exp_q.pop_front();
    n_checks++; if ({bif.bp_csrf_branch_num_add, bif.bp_csrf_branch_predicted_add} !== 2'b10) $display("FAIL pulse_after got %b want 10", {bif.bp_csrf_branch_num_add, bif.bp_csrf_branch_predicted_add}); else n_pass++;
    n_checks++; if ({bif.bp_csrf_branch_num_add, bif.bp_csrf_branch_predicted_add} !== want) $display("FAIL pulse_model got %b want %b", {bif.bp_csrf_branch_num_add, bif.bp_csrf_branch_predicted_add}, want); else n_pass++;
    n_checks++; if (bif.bp_fetch_pht_idx[0] !== 1'b1) $display("FAIL ghr_bit0 got %b want 1", bif.bp_fetch_pht_idx[0]); else n_pass++;
    tick();
    drive_fetch(1, K_BR, 6, 7, 16, 0, pc_for_idx(5), 32'h0);
    #1;
    n_checks++; if (bif.bp_fetch_pred_taken !== 1'b1) $display("FAIL new_cnt_visible got %b want 1", bif.bp_fetch_pred_taken); else n_pass++;
    tick();
  endtask

  task automatic test_reset_during_commit();
    do_reset();
    drive_commit(1, 7, 1, 1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive_commit(0, 0, 0, 0);
    drive_fetch(1, K_BR, 1, 2, 40, 0, 32'h201C, 32'h0);
    #1;
    n_checks++; if (bif.bp_fetch_pht_idx !== 10'd7) $display("FAIL rstc_idx got %h want 007", bif.bp_fetch_pht_idx); else n_pass++;
    n_checks++; if (bif.bp_fetch_pred_taken !== 1'b0) $display("FAIL rstc_cnt got %b want 0", bif.bp_fetch_pred_taken); else n_pass++;
    n_checks++; if ({bif.bp_csrf_branch_num_add, bif.bp_csrf_branch_predicted_add} !== 2'b00) $display("FAIL rstc_csrf got %b want 00", {bif.bp_csrf_branch_num_add, bif.bp_csrf_branch_predicted_add}); else n_pass++;
    n_checks++; if (dut_fetch() !== model_fetch()) $display("FAIL rstc_vec got %h want %h", dut_fetch(), model_fetch()); else n_pass++;
    tick();
  endtask

  task automatic test_valid_low();
    logic [31:0] pc;
    for (int i = 0; i < 12; i++) begin
      pc = $urandom();
      pc[1:0] = 2'b00;
      drive_fetch(0, i % 4, 1, 5, 8, 0, pc, $urandom());
      #1;
      n_checks++; if (dut_fetch() !== '0) $display("FAIL valid_low%0d got %h want 0", i, dut_fetch()); else n_pass++;
      tick();
    end
  endtask

  function automatic int pick_reg();
    case ($urandom_range(0, 3))
      0: return 1;
      1: return 5;
      2: return 0;
      default: return int'($urandom_range(0, 31));
    endcase
  endfunction

  task automatic test_random();
    int k, rd, rs1, imm, f3;
    logic [31:0] pc;
    logic [1:0] want;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      k = int'($urandom_range(0, 3));
      rd = pick_reg();
      rs1 = pick_reg();
      f3 = int'($urandom_range(0, 7));
      if (k == K_JALR && $urandom_range(0, 3) != 0) f3 = 0;
      if (k == K_JAL) imm = (int'($urandom_range(0, (1 << 20) - 1)) - (1 << 19)) * 2;
      else if (k == K_BR) imm = (int'($urandom_range(0, 4095)) - 2048) * 2;
      else imm = int'($urandom_range(0, 4095)) - 2048;
      pc = $urandom();
      if ($urandom_range(0, 1) == 0) pc = 32'h8000 + 32'($urandom_range(0, 15) * 4);
      pc[1:0] = 2'b00;
      drive_fetch($urandom_range(0, 4) != 0, k, rd, rs1, imm, f3, pc, $urandom());
      drive_commit($urandom_range(0, 1) == 1, int'($urandom_range(0, 31)),
                   $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      #1;
      n_checks++; if (dut_fetch() !== model_fetch()) $display("FAIL rand_fetch c%0d got %h want %h", c, dut_fetch(), model_fetch()); else n_pass++;
      want = exp_q.pop_front();
      n_checks++; if ({bif.bp_csrf_branch_num_add, bif.bp_csrf_branch_predicted_add} !== want) $display("FAIL rand_csrf c%0d got %b want %b", c, {bif.bp_csrf_branch_num_add, bif.bp_csrf_branch_predicted_add}, want); else n_pass++;
      tick();
    end
    drive_commit(0, 0, 0, 0);
  endtask

  initial begin
    drive_fetch(0, K_OTHER, 0, 0, 0, 0, 32'h0, 32'h0);
    drive_commit(0, 0, 0, 0);
    test_reset();
    test_jal();
    test_jalr();
    test_branch_train();
    test_commit_pulse();
    test_reset_during_commit();
    test_valid_low();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
